onewire_master: RTL and testbench
=================================

Name: onewire_master

Overview:
- Bit/byte-level 1-Wire bus master that generates reset/presence, write and read time slots on a single open-drain line.
- Sits directly downstream of the temperature sensor controller. The controller issues commands through a valid/ready interface. This block drives owr_out (the pad pull-down) and samples owr_in.
- All slot timing derives from a microsecond tick, so simulation can shrink it via a parameter.

Parameters:
- US_CYCLES, 12, clk cycles per microsecond (sim uses 1; legal range 1..255).
- RECOVERY_US, 2, bus-high recovery time appended to every slot, in µs.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous assert, active-low (0 = reset)
- cmd_valid  in  1  command request
- cmd_ready  out  1  high when a command can be accepted (idle)
- cmd  in  3  0=RESET, 1=WRITE_BIT, 2=READ_BIT, 3=WRITE_BYTE, 4=READ_BYTE, 5..7 reserved
- wr_data  in  8  write payload; bit0 is used for WRITE_BIT
- rd_data  out  8  read result; bit0 holds the READ_BIT result, upper bits are 0
- presence  out  1  presence detected on the last RESET
- short_err  out  1  bus still low at the end of the last RESET
- done  out  1  one-cycle pulse when a command completes
- owr_in  in  1  raw bus level from pad
- owr_out  out  1  1 = pull bus low; 0 = release

Behaviour:
- Reset values: cmd_ready=1, rd_data=0, presence=0, short_err=0, done=0, owr_out=0 (bus released). Reset mid-slot releases the bus immediately because reset is asynchronous.
- owr_in passes through a 2-flop synchronizer. All sampling uses the synchronized value, so it lags the pad by 2 cycles.
- Prescaler counts 0..US_CYCLES-1 and emits us_tick on wrap. A 10-bit µs counter clears on every state change.
- Handshake:
  - A command is accepted in the cycle where cmd_valid && cmd_ready.
  - cmd and wr_data are latched in that cycle, and cmd_ready drops the next cycle.
  - cmd_valid while busy is ignored and not queued.
  - A reserved opcode is accepted, produces done one cycle later, and changes nothing else.
- FSM states: IDLE, RST_LOW, RST_WAIT, SLOT_LOW, SLOT_HIGH, RECOVER, FINISH.
- RESET sequence:
  - RST_LOW: owr_out=1 for 480 µs.
  - RST_WAIT: release the bus. At µs 70, latch presence = !owr_in_s.
  - At µs 480 of RST_WAIT, latch short_err = !owr_in_s, then go to FINISH.
- Bit slot (shared by write and read):
  - SLOT_LOW: owr_out=1 for T_LOW. T_LOW = 6 µs for write-1 and for read; 60 µs for write-0.
  - SLOT_HIGH: release until the slot reaches 70 µs total (64 / 10 / 64 µs respectively).
  - Read sampling: at µs 9 of SLOT_HIGH (15 µs after slot start), shift owr_in_s into the shift register.
  - RECOVER: released for RECOVERY_US.
- Byte commands run 8 slots LSB-first with a 3-bit bit counter.
  - Write: shift wr_data right.
  - Read: shift in from the MSB side, so after 8 slots rd_data[0] is the first bit received.
- FINISH:
  - rd_data updates only for READ_BIT / READ_BYTE.
  - done=1 for one cycle; cmd_ready=1 in the same cycle; return to IDLE.
  - A new command may be accepted in that cycle.
- Latency at US_CYCLES=1, from the accept cycle to the done cycle, each within ±3 cycles:
  - RESET ≈ 960 cycles
  - bit ≈ 72 cycles
  - byte ≈ 576 cycles
- presence and short_err hold until the next RESET completes. owr_out is glitch-free because it is a registered output.

Decomposition:
- Package onewire_pkg:
  - command encodings;
  - timing constants T_RST_LOW=480, T_PRES_SAMPLE=70, T_RST_WAIT=480, T_SLOT=70, T_LOW0=60, T_LOW1=6, T_RD_SAMPLE=15;
  - FSM state enum.
- Sub-module onewire_tick: prescaler plus µs counter, taking a clear input.
- Synchronizer and FSM stay in onewire_master.

Test Plan (US_CYCLES=1; bus model = wired-AND of owr_out and slave pull-down):
- RESET with slave pulling low from µs 15 to 135 after release -> owr_out low for 480 cycles, presence=1, short_err=0, single done pulse.
- RESET with no slave; then RESET with bus held low permanently -> first gives presence=0, short_err=0; second gives presence=1, short_err=1.
- WRITE_BYTE 0xA5 -> 8 slots, LSB first: bit pattern 1,0,1,0,0,1,0,1. Measured low widths are 6 µs for 1 and 60 µs for 0, with ≥2 µs high between slots.
- READ_BYTE with slave holding the line low through µs 30 on slots 1,3,4 -> rd_data=0xE5, done once.
- cmd_valid held high with WRITE_BIT during a running READ_BIT -> second command accepted only in the FINISH cycle, with no lost or duplicated done.
- rst asserted mid-SLOT_LOW -> owr_out=0 in the same cycle; all outputs at reset values; after release a new RESET completes normally.

Source files
------------

// File: rtl/onewire_pkg.sv
// 1-Wire master shared encodings, slot timing and FSM states.
// Times are in microseconds of the prescaled tick.
package onewire_pkg;

  localparam logic [2:0] CMD_RESET   = 3'd0;
  localparam logic [2:0] CMD_WR_BIT  = 3'd1;
  localparam logic [2:0] CMD_RD_BIT  = 3'd2;
  localparam logic [2:0] CMD_WR_BYTE = 3'd3;
  localparam logic [2:0] CMD_RD_BYTE = 3'd4;

  localparam logic [9:0] T_RST_LOW     = 10'd480;
  localparam logic [9:0] T_PRES_SAMPLE = 10'd70;
  localparam logic [9:0] T_RST_WAIT    = 10'd480;
  localparam logic [9:0] T_SLOT        = 10'd70;
  localparam logic [9:0] T_LOW0        = 10'd60;
  localparam logic [9:0] T_LOW1        = 10'd6;
  localparam logic [9:0] T_RD_SAMPLE   = 10'd15;

  typedef enum logic [2:0] {
    IDLE,
    RST_LOW,
    RST_WAIT,
    SLOT_LOW,
    SLOT_HIGH,
    RECOVER,
    FINISH
  } state_e;

  function automatic logic is_slot_cmd(
    input logic [2:0] c
  );
    return (c != CMD_RESET) && (c <= CMD_RD_BYTE);
  endfunction

  function automatic logic [9:0] slot_low_us(
    input logic is_wr,
    input logic b
  );
    return (is_wr && !b) ? T_LOW0 : T_LOW1;
  endfunction

endpackage

// File: rtl/onewire_tick.sv
// Microsecond prescaler and per-state microsecond counter.
// clr restarts both so every state begins at us 0.
module onewire_tick #(
  parameter int US_CYCLES = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  output logic       us_tick,
  output logic [9:0] us_cnt
);

  localparam logic [7:0] PRE_MAX = 8'(US_CYCLES - 1);

  logic [7:0] pre;

  assign us_tick = (pre == PRE_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre    <= '0;
      us_cnt <= '0;
    end else if (clr) begin
      pre    <= '0;
      us_cnt <= '0;
    end else begin
      pre <= us_tick ? 8'd0 : pre + 8'd1;
      if (us_tick) begin
        us_cnt <= us_cnt + 10'd1;
      end
    end
  end

endmodule

// File: rtl/onewire_master.sv
// Bit/byte 1-Wire bus master: reset/presence, write and read slots.
// owr_out is registered from the next state so the pad never glitches.
module onewire_master
  import onewire_pkg::*;
#(
  parameter int US_CYCLES   = 12,
  parameter int RECOVERY_US = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       presence,
  output logic       short_err,
  output logic       done,
  input  logic       owr_in,
  output logic       owr_out
);

  localparam logic [9:0] T_REC = 10'(RECOVERY_US);

  state_e state;
  state_e state_n;

  logic       owr_s1;
  logic       owr_s;
  logic [2:0] cmd_q;
  logic [7:0] sh;
  logic [2:0] bit_cnt;
  logic       pres_q;

  logic       us_tick;
  logic [9:0] us_cnt;
  logic [9:0] t_low;
  logic [9:0] dur;
  logic       t_end;
  logic       accept;
  logic       clr;
  logic       is_wr;
  logic       is_rd;
  logic       multi;
  logic       pres_pt;
  logic       rd_pt;

  assign cmd_ready = (state == IDLE) || (state == FINISH);
  assign done      = (state == FINISH);
  assign accept    = cmd_valid && cmd_ready;

  assign is_wr = (cmd_q == CMD_WR_BIT) || (cmd_q == CMD_WR_BYTE);
  assign is_rd = (cmd_q == CMD_RD_BIT) || (cmd_q == CMD_RD_BYTE);
  assign multi = (cmd_q == CMD_WR_BYTE) || (cmd_q == CMD_RD_BYTE);
  assign t_low = slot_low_us(is_wr, sh[0]);

  assign clr = accept || (state_n != state);

  onewire_tick #(
    .US_CYCLES(US_CYCLES)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .us_tick(us_tick),
    .us_cnt (us_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owr_s1 <= 1'b1;
      owr_s  <= 1'b1;
    end else begin
      owr_s1 <= owr_in;
      owr_s  <= owr_s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    dur = '0;
    unique case (state)
      RST_LOW:   dur = T_RST_LOW;
      RST_WAIT:  dur = T_RST_WAIT;
      SLOT_LOW:  dur = t_low;
      SLOT_HIGH: dur = T_SLOT - t_low;
      RECOVER:   dur = T_REC;
      default:   dur = '0;
    endcase
  end

  assign t_end   = us_tick && (us_cnt == dur - 10'd1);
  assign pres_pt = us_tick && (us_cnt == T_PRES_SAMPLE);
  // read sample lands 15 us after the slot start
  assign rd_pt   = us_tick && (us_cnt == T_RD_SAMPLE - T_LOW1);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, FINISH: begin
        state_n = IDLE;
        if (accept) begin
          unique case (1'b1)
            (cmd == CMD_RESET): state_n = RST_LOW;
            is_slot_cmd(cmd):   state_n = SLOT_LOW;
            default:            state_n = FINISH;
          endcase
        end
      end
      RST_LOW: begin
        if (t_end) state_n = RST_WAIT;
      end
      RST_WAIT: begin
        if (t_end) state_n = FINISH;
      end
      SLOT_LOW: begin
        if (t_end) state_n = SLOT_HIGH;
      end
      SLOT_HIGH: begin
        if (t_end) state_n = RECOVER;
      end
      RECOVER: begin
        if (t_end) begin
          state_n = (multi && bit_cnt != 3'd7) ? SLOT_LOW : FINISH;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owr_out   <= 1'b0;
      cmd_q     <= '0;
      sh        <= '0;
      bit_cnt   <= '0;
      pres_q    <= 1'b0;
      rd_data   <= '0;
      presence  <= 1'b0;
      short_err <= 1'b0;
    end else begin
      owr_out <= (state_n == RST_LOW) || (state_n == SLOT_LOW);
      if (accept) begin
        cmd_q   <= cmd;
        sh      <= wr_data;
        bit_cnt <= '0;
      end
      if (state == RST_WAIT && pres_pt) begin
        pres_q <= !owr_s;
      end
      // results become visible together with done
      if (state == RST_WAIT && t_end) begin
        presence  <= pres_q;
        short_err <= !owr_s;
      end
      if (state == SLOT_HIGH && is_rd && rd_pt) begin
        sh <= {owr_s, sh[7:1]};
      end
      if (state == SLOT_HIGH && is_wr && t_end) begin
        sh <= sh >> 1;
      end
      if (state == RECOVER && t_end) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (state_n == FINISH && is_rd) begin
          rd_data <= multi ? sh : {7'd0, sh[7]};
        end
      end
    end
  end

endmodule

// File: tb/tb_onewire_master.sv
// Bench for onewire_master at US_CYCLES=1 with a scripted slave.
// Bus level is the wired-AND of the master pull-down and the slave.
module tb_onewire_master;
  import onewire_pkg::*;

  localparam int NC       = 16384;
  localparam int SLOT_CYC = 70 + 2;
  localparam int RST_CYC  = 480 + 480;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd = 3'd0;
  logic [7:0] wr_data = 8'd0;
  logic       cmd_ready;
  logic       done;
  logic       presence;
  logic       short_err;
  logic       owr_in;
  logic       owr_out;
  logic [7:0] rd_data;

  always #5 clk = ~clk;

  onewire_master #(
    .US_CYCLES  (1),
    .RECOVERY_US(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd      (cmd),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .presence (presence),
    .short_err(short_err),
    .done     (done),
    .owr_in   (owr_in),
    .owr_out  (owr_out)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // slave: 0 none, 1 presence pulse, 2 bus stuck low, 3 read pattern
  int         mode = 0;
  logic [7:0] rd_mask = 8'd0;
  int         rise_c = -1000;
  int         fall_c = -1000;
  int         low_len = 0;
  int         slot_idx = -1;
  logic       prev_out = 1'b0;
  logic       slave_low;
  int         lows[$];
  int         highs[$];
  int         done_cnt = 0;

  always_comb begin
    slave_low = 1'b0;
    if (mode == 1) begin
      slave_low = (low_len >= 400) && !owr_out &&
                  ((cyc - fall_c) >= 15) && ((cyc - fall_c) < 135);
    end else if (mode == 2) begin
      slave_low = 1'b1;
    end else if (mode == 3) begin
      slave_low = (slot_idx >= 0) && (slot_idx < 8) &&
                  rd_mask[slot_idx[2:0]] && ((cyc - rise_c) <= 30);
    end
  end

  assign owr_in = !owr_out && !slave_low;

  always @(negedge clk) begin
    if (owr_out && !prev_out) begin
      highs.push_back(cyc - fall_c);
      rise_c = cyc;
      slot_idx++;
    end
    if (!owr_out && prev_out) begin
      low_len = cyc - rise_c;
      lows.push_back(low_len);
      fall_c = cyc;
    end
    prev_out = owr_out;
  end

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      if (errors < 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                 nm, act, want, cyc);
    end
  endtask

  // reference model: expected waveform per cycle and result updates
  typedef struct {
    int         t;
    logic [7:0] rd;
    logic       pres;
    logic       shrt;
  } upd_t;

  upd_t       uq[$];
  bit         exp_owr[NC];
  bit         exp_done[NC];
  bit         exp_busy[NC];
  bit         model_on = 1'b1;
  logic [7:0] cur_rd = 8'd0;
  logic       cur_pres = 1'b0;
  logic       cur_short = 1'b0;
  logic [7:0] last_rd = 8'd0;
  logic       last_pres = 1'b0;
  logic       last_short = 1'b0;

  function automatic logic bus_bit(input int k);
    return !(mode == 3 && rd_mask[k[2:0]]);
  endfunction

  task automatic plan(input int ta, input logic [2:0] c,
                      input logic [7:0] wd, output int td);
    int   n;
    int   w;
    upd_t u;
    td = ta + 1;
    if (c == CMD_RESET) begin
      for (int i = 1; i <= 480; i++) exp_owr[ta+i] = 1'b1;
      td         = ta + RST_CYC + 1;
      last_pres  = (mode == 1) || (mode == 2);
      last_short = (mode == 2);
    end else if (c <= CMD_RD_BYTE) begin
      n = (c >= CMD_WR_BYTE) ? 8 : 1;
      for (int k = 0; k < n; k++) begin
        if (c == CMD_WR_BIT || c == CMD_WR_BYTE) w = wd[k] ? 6 : 60;
        else w = 6;
        for (int i = 0; i < w; i++) exp_owr[ta+1+SLOT_CYC*k+i] = 1'b1;
      end
      td = ta + 1 + SLOT_CYC * n;
      if (c == CMD_RD_BIT) last_rd = {7'd0, bus_bit(0)};
      if (c == CMD_RD_BYTE)
        for (int k = 0; k < 8; k++) last_rd[k] = bus_bit(k);
    end
    for (int i = ta + 1; i < td; i++) exp_busy[i] = 1'b1;
    exp_done[td] = 1'b1;
    u.t    = td;
    u.rd   = last_rd;
    u.pres = last_pres;
    u.shrt = last_short;
    uq.push_back(u);
  endtask

  always @(negedge clk) begin
    if (rst && model_on && cyc < NC) begin
      while (uq.size() > 0 && uq[0].t <= cyc) begin
        cur_rd    = uq[0].rd;
        cur_pres  = uq[0].pres;
        cur_short = uq[0].shrt;
        uq.delete(0);
      end
      chk("owr_out", 32'(owr_out), 32'(exp_owr[cyc]));
      chk("done", 32'(done), 32'(exp_done[cyc]));
      chk("cmd_ready", 32'(cmd_ready), 32'(!exp_busy[cyc]));
      chk("rd_data", 32'(rd_data), 32'(cur_rd));
      chk("presence", 32'(presence), 32'(cur_pres));
      chk("short_err", 32'(short_err), 32'(cur_short));
    end
  end

  task automatic wait_done(output int tdo);
    int n = 0;
    tdo = -1;
    while (tdo < 0 && n < 1500) begin
      if (done) tdo = cyc;
      else begin
        @(negedge clk);
        n++;
      end
    end
    if (tdo < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", n);
    end
  endtask

  task automatic issue(input logic [2:0] c, input logic [7:0] wd,
                       output int ta, output int tdo);
    int n = 0;
    int tp;
    @(negedge clk);
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    ta = cyc;
    plan(ta, c, wd, tp);
    cmd       = c;
    wr_data   = wd;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(tdo);
  endtask

  function automatic logic near(input int v, input int ref_v);
    return (v >= ref_v - 3) && (v <= ref_v + 3);
  endfunction

  initial begin
    int ta;
    int td;
    int ta1;
    int td1;
    int td2;
    int tp;
    int d0;
    int wexp[8];
    wexp = '{6, 60, 6, 60, 60, 6, 60, 6};

    #1 rst = 1'b0;
    #10;
    chk("rst_owr_out", 32'(owr_out), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_presence", 32'(presence), 32'd0);
    chk("rst_short_err", 32'(short_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // RESET with a presence pulse
    mode = 1;
    lows.delete();
    d0 = done_cnt;
    issue(CMD_RESET, 8'd0, ta, td);
    @(negedge clk);
    chk("reset1_latency_ok", 32'(near(td - ta, 960)), 32'd1);
    chk("reset1_low_count", 32'(lows.size()), 32'd1);
    if (lows.size() > 0) chk("reset1_low_width", 32'(lows[0]), 32'd480);
    chk("reset1_presence", 32'(presence), 32'd1);
    chk("reset1_short", 32'(short_err), 32'd0);
    chk("reset1_done_pulses", 32'(done_cnt - d0), 32'd1);

    // RESET with no slave, then with bus stuck low
    mode = 0;
    issue(CMD_RESET, 8'd0, ta, td);
    chk("reset2_presence", 32'(presence), 32'd0);
    chk("reset2_short", 32'(short_err), 32'd0);
    mode = 2;
    issue(CMD_RESET, 8'd0, ta, td);
    chk("reset3_presence", 32'(presence), 32'd1);
    chk("reset3_short", 32'(short_err), 32'd1);
    mode = 0;

    // WRITE_BYTE 0xA5, LSB first
    lows.delete();
    highs.delete();
    issue(CMD_WR_BYTE, 8'hA5, ta, td);
    @(negedge clk);
    chk("wbyte_latency_ok", 32'(near(td - ta, 576)), 32'd1);
    chk("wbyte_slots", 32'(lows.size()), 32'd8);
    for (int i = 0; i < 8 && i < lows.size(); i++)
      chk($sformatf("wbyte_low%0d", i), 32'(lows[i]), 32'(wexp[i]));
    for (int i = 1; i < highs.size(); i++)
      chk($sformatf("wbyte_gap%0d", i), 32'(highs[i] >= 2), 32'd1);

    // READ_BYTE, slave low through 30 us on slots 1,3,4
    mode     = 3;
    rd_mask  = 8'b0001_1010;
    slot_idx = -1;
    d0       = done_cnt;
    issue(CMD_RD_BYTE, 8'd0, ta, td);
    chk("rbyte_data", 32'(rd_data), 32'hE5);
    @(negedge clk);
    chk("rbyte_done_pulses", 32'(done_cnt - d0), 32'd1);
    mode = 0;

    // reserved opcode completes in one cycle
    issue(3'd6, 8'hFF, ta, td);
    chk("reserved_latency", 32'(td - ta), 32'd1);
    chk("reserved_rd_kept", 32'(rd_data), 32'hE5);

    // WRITE_BIT held valid while READ_BIT runs
    @(negedge clk);
    d0  = done_cnt;
    ta1 = cyc;
    plan(ta1, CMD_RD_BIT, 8'd0, td1);
    plan(td1, CMD_WR_BIT, 8'h01, tp);
    cmd       = CMD_RD_BIT;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd     = CMD_WR_BIT;
    wr_data = 8'h01;
    wait_done(td1);
    chk("b2b_ready_in_finish", 32'(cmd_ready), 32'd1);
    chk("b2b_rbit_data", 32'(rd_data), 32'h01);
    chk("b2b_bit_latency_ok", 32'(near(td1 - ta1, 72)), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_accepted", 32'(cmd_ready), 32'd0);
    wait_done(td2);
    chk("b2b_second_latency_ok", 32'(near(td2 - td1, 72)), 32'd1);
    @(negedge clk);
    chk("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);

    // async reset in the middle of a write-0 low phase
    @(negedge clk);
    ta = cyc;
    plan(ta, CMD_WR_BIT, 8'h00, tp);
    cmd       = CMD_WR_BIT;
    wr_data   = 8'h00;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_owr_low", 32'(owr_out), 32'd1);
    model_on = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_owr_out", 32'(owr_out), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
    chk("mid_rst_presence", 32'(presence), 32'd0);
    chk("mid_rst_short", 32'(short_err), 32'd0);
    for (int i = cyc; i < NC; i++) begin
      exp_owr[i]  = 1'b0;
      exp_done[i] = 1'b0;
      exp_busy[i] = 1'b0;
    end
    uq.delete();
    cur_rd     = 8'd0;
    cur_pres   = 1'b0;
    cur_short  = 1'b0;
    last_rd    = 8'd0;
    last_pres  = 1'b0;
    last_short = 1'b0;
    @(negedge clk);
    rst      = 1'b1;
    model_on = 1'b1;

    mode = 1;
    issue(CMD_RESET, 8'd0, ta, td);
    chk("post_rst_presence", 32'(presence), 32'd1);
    chk("post_rst_short", 32'(short_err), 32'd0);
    chk("post_rst_latency_ok", 32'(near(td - ta, 960)), 32'd1);
    mode = 0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
